pipe_stage_ctrl: RTL and testbench

- Parametrised pipeline sequencer for the MIPS31 pipeline; supersedes the fixed 5-stage enable ramp.
- Per stage it tracks a valid bit, generates register-load enables and bubble indicators, applies stall and flush requests, and runs a stall watchdog.
- Sits beside the CPU top. stage_ena drives the PC and inter-stage registers; bubble drives the zero-instruction muxes.

---
 rtl/pipe_stage_ctrl.sv | 69 ++++++
 tb/tb_pipe_stage_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: parametrised pipeline sequencer (valid tracking, load enables, bubbles, stall/flush, stall watchdog)
// Ports: clk, reset (async active-high), cpu_ena (global run), stall_req/flush_req (per stage),
//        stage_ena/stage_valid/bubble (per stage), drained, stall_timeout (sticky), stall_cnt.
// Optional: define PIPE_PERF_CNT_EN to add perf_stall_cycles, perf_flush_cycles and perf_retired.
module pipe_stage_ctrl #(
  parameter int STAGES = 5,
  parameter int WD_W = 8,
  parameter int MAX_STALL = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ena,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stage_ena,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] bubble,
  output logic              drained,
  output logic              stall_timeout,
  output logic [WD_W-1:0]   stall_cnt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_cycles,
  output logic [31:0]       perf_retired
`endif
);
  logic [STAGES-1:0] valid, hold, fmask, in_valid, valid_nxt;
  logic [WD_W-1:0] cnt_nxt;
  logic wd_hit;
  // A request at stage k affects k and every stage upstream of it
  for (genvar i = 0; i < STAGES; i++) begin : g_mask
    assign hold[i] = |stall_req[STAGES-1:i];
    assign fmask[i] = |flush_req[STAGES-1:i];
  end
  assign in_valid = {valid[STAGES-2:0] & ~hold[STAGES-2:0] & ~fmask[STAGES-2:0], 1'b1};
  assign stage_ena = {STAGES{cpu_ena & ~reset}} & ~hold;
  assign bubble = stage_ena & ~in_valid;
  assign valid_nxt = (hold & valid & ~fmask) | (~hold & in_valid);
  assign stage_valid = valid;
  assign drained = ~|valid;
  // Watchdog only counts while a held stage actually contains an instruction
  assign wd_hit = |(valid & hold);
  assign cnt_nxt = wd_hit ? stall_cnt + WD_W'(~&stall_cnt) : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      stall_cnt <= '0;
      stall_timeout <= 1'b0;
    end else if (cpu_ena) begin
      valid <= valid_nxt;
      stall_cnt <= cnt_nxt;
      stall_timeout <= stall_timeout | (cnt_nxt >= WD_W'(MAX_STALL));
    end
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
      perf_retired <= '0;
    end else if (cpu_ena) begin
      perf_stall_cycles <= perf_stall_cycles + 32'(|stall_req);
      perf_flush_cycles <= perf_flush_cycles + 32'(|flush_req);
      perf_retired <= perf_retired + 32'(valid[STAGES-1]);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed and randomized check of pipe_stage_ctrl against an index-based pipeline model
module tb_pipe_stage_ctrl;
  localparam int S = 5;
  localparam int W = 8;
  localparam int MX = 200;
  logic clk = 0;
  logic reset, cpu_ena;
  logic [S-1:0] stall_req, flush_req, stage_ena, stage_valid, bubble;
  logic drained, stall_timeout;
  logic [W-1:0] stall_cnt;
  int total = 0;
  int bad = 0;
  bit mv[S];
  int mcnt;
  bit mto;
  always #5 clk = ~clk;
  pipe_stage_ctrl #(.STAGES(S), .WD_W(W), .MAX_STALL(MX)) dut (
    .clk(clk), .reset(reset), .cpu_ena(cpu_ena), .stall_req(stall_req), .flush_req(flush_req),
    .stage_ena(stage_ena), .stage_valid(stage_valid), .bubble(bubble), .drained(drained),
    .stall_timeout(stall_timeout), .stall_cnt(stall_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int top(input logic [S-1:0] r);
    int h = -1;
    for (int i = 0; i < S; i++) if (r[i]) h = i;
    return h;
  endfunction
  function automatic logic [S-1:0] mvec();
    logic [S-1:0] v;
    for (int i = 0; i < S; i++) v[i] = mv[i];
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < S; i++) mv[i] = 0;
    mcnt = 0;
    mto = 0;
  endtask
  task automatic cycle(input logic e, input logic [S-1:0] st, input logic [S-1:0] fl);
    int hs, hf;
    logic [S-1:0] ee, eb;
    bit nv[S];
    bit inc, busy;
    cpu_ena = e;
    stall_req = st;
    flush_req = fl;
    #1;
    hs = top(st);
    hf = top(fl);
    busy = 0;
    for (int i = 0; i < S; i++) begin
      inc = (i == 0) ? 1'b1 : (mv[i-1] && (i - 1 > hs) && (i - 1 > hf));
      ee[i] = e && (i > hs);
      eb[i] = ee[i] && !inc;
      nv[i] = (i <= hs) ? ((i <= hf) ? 1'b0 : mv[i]) : inc;
      if (i <= hs && mv[i]) busy = 1;
    end
    check("valid", 32'(stage_valid), 32'(mvec()));
    check("ena", 32'(stage_ena), 32'(ee));
    check("bubble", 32'(bubble), 32'(eb));
    check("drained", 32'(drained), 32'(mvec() == '0));
    check("cnt", 32'(stall_cnt), 32'(mcnt));
    check("timeout", 32'(stall_timeout), 32'(mto));
    @(posedge clk);
    if (e) begin
      for (int i = 0; i < S; i++) mv[i] = nv[i];
      mcnt = busy ? ((mcnt < 255) ? mcnt + 1 : 255) : 0;
      if (mcnt >= MX) mto = 1;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, '0, '0);
  endtask
  initial begin
    reset = 1;
    cpu_ena = 1;
    stall_req = '0;
    flush_req = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ena", 32'(stage_ena), 32'h0);
    check("rst_bubble", 32'(bubble), 32'h0);
    check("rst_drained", 32'(drained), 32'h1);
    check("rst_valid", 32'(stage_valid), 32'h0);
    reset = 0;
    for (int k = 0; k < S; k++) begin
      cycle(1'b1, '0, '0);
      check("fill", 32'(stage_valid), 32'((1 << (k + 1)) - 1));
    end
    cycle(1'b1, 5'b00100, '0);
    check("loaduse", 32'(stage_valid), 32'h17);
    idle(S);
    cycle(1'b1, '0, 5'b00010);
    check("flush", 32'(stage_valid), 32'h19);
    idle(S);
    cycle(1'b1, 5'b00100, 5'b00010);
    check("stallflush", 32'(stage_valid), 32'h14);
    idle(S);
    for (int k = 0; k < 10; k++) cycle(1'b0, S'($urandom), S'($urandom));
    check("freeze", 32'(stage_valid), 32'h1f);
    for (int k = 0; k < 260; k++) cycle(1'b1, 5'b00001, '0);
    check("wd_sat", 32'(stall_cnt), 32'd255);
    idle(3);
    check("wd_sticky", 32'(stall_timeout), 32'h1);
    for (int k = 0; k < 20; k++) cycle(1'b1, 5'b01000, '0);
    #2;
    reset = 1;
    #1;
    model_reset();
    check("arst_valid", 32'(stage_valid), 32'h0);
    check("arst_timeout", 32'(stall_timeout), 32'h0);
    check("arst_ena", 32'(stage_ena), 32'h0);
    check("arst_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 500; k++)
      cycle($urandom_range(0, 9) != 0,
            ($urandom_range(0, 3) == 0) ? S'($urandom) : '0,
            ($urandom_range(0, 5) == 0) ? S'($urandom) : '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
